div_mant: RTL and testbench

//  Sequential restoring divider for IEEE754 single-precision mantissas: Q = A / B,

---
 rtl/div_mant_pkg.sv | 28 ++
 rtl/div_mant_if.sv | 16 +
 rtl/div_mant_sub.sv | 29 ++
 rtl/div_mant.sv | 66 ++++++
 tb/tb_div_mant.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/div_mant_pkg.sv
// div_mant_pkg: shared widths, FSM encoding, result record and quotient normalizer
package div_mant_pkg;
    localparam int MANT_W   = 24;
    localparam int DIV_ITER = MANT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [MANT_W-1:0] out;
        logic              exp_dec;
        logic              sticky;
        logic              dbz;
    } res_t;

    // The LSB dropped by a right-normalize must still feed sticky for rounding
    function automatic res_t normalize(input logic [MANT_W:0] q, input logic rem_nz);
        res_t n;
        n.out     = q[MANT_W] ? q[MANT_W:1] : q[MANT_W-1:0];
        n.exp_dec = ~q[MANT_W];
        n.sticky  = rem_nz | (q[MANT_W] & q[0]);
        n.dbz     = 1'b0;
        return n;
    endfunction
endpackage

// File: rtl/div_mant_if.sv
// div_mant_if: request/result bundle between the FP divide path and the mantissa divider
interface div_mant_if;
    import div_mant_pkg::*;
    logic              start;
    logic [MANT_W-1:0] A;
    logic [MANT_W-1:0] B;
    logic              busy;
    logic              done;
    logic [MANT_W-1:0] out;
    logic              exp_dec;
    logic              sticky;
    logic              dbz;

    modport master (output start, A, B, input busy, done, out, exp_dec, sticky, dbz);
    modport slave  (input start, A, B, output busy, done, out, exp_dec, sticky, dbz);
endinterface

// File: rtl/div_mant_sub.sv
// div_mant_sub: ripple trial subtractor and counter adder used by the mantissa divider
module sub_26bit (
    input  logic [25:0] in1,
    input  logic [25:0] in2,
    output logic [25:0] D,
    output logic        Bout
);
    logic [26:0] b;
    assign b[0] = 1'b0;
    for (genvar i = 0; i < 26; i++) begin : g_fs
        assign D[i]   = in1[i] ^ in2[i] ^ b[i];
        assign b[i+1] = (~in1[i] & in2[i]) | (~(in1[i] ^ in2[i]) & b[i]);
    end
    assign Bout = b[26];
endmodule

module adder_5bit (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       cin,
    output logic [4:0] s
);
    logic [5:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 5; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
endmodule

// File: rtl/div_mant.sv
// div_mant: restoring mantissa divider, one quotient bit per cycle, normalized result
module div_mant
    import div_mant_pkg::*;
(
    input logic       CLK,
    input logic       RST,
    div_mant_if.slave bus
);
    state_t            state, state_nxt;
    logic [25:0]       r, d, r_nxt;
    logic [MANT_W-1:0] q, b_reg;
    logic [MANT_W:0]   q_nxt;
    logic [4:0]        cnt, cnt_dec;
    logic              borrow, accept, last;
    res_t              res;

    sub_26bit u_sub (.in1(r), .in2({2'b0, b_reg}), .D(d), .Bout(borrow));
    // count - 1 as count + all-ones
    adder_5bit u_cnt (.a(cnt), .b(5'b11111), .cin(1'b0), .s(cnt_dec));

    assign accept = (state == S_IDLE) && bus.start;
    assign last   = (cnt_dec == '0);
    assign r_nxt  = (borrow ? r : d) << 1;
    assign q_nxt  = {q, ~borrow};

    always_ff @(posedge CLK or negedge RST)
        if (!RST) state <= S_IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = (state == S_IDLE) ? (bus.start ? ((bus.B == '0) ? S_DONE : S_RUN) : S_IDLE)
                  : (state == S_RUN)  ? (last ? S_DONE : S_RUN)
                  : S_IDLE;
    end

    always_comb begin
        bus.busy    = state != S_IDLE;
        bus.done    = state == S_DONE;
        bus.out     = res.out;
        bus.exp_dec = res.exp_dec;
        bus.sticky  = res.sticky;
        bus.dbz     = res.dbz;
    end

    // Results clear on accept and only reload when the final quotient bit lands
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
            b_reg <= '0;
            res   <= '0;
        end else if (accept) begin
            r       <= {2'b0, bus.A};
            q       <= '0;
            cnt     <= 5'(DIV_ITER);
            b_reg   <= bus.B;
            res     <= '0;
            res.dbz <= bus.B == '0;
        end else if (state == S_RUN) begin
            r   <= r_nxt;
            q   <= q_nxt[MANT_W-1:0];
            cnt <= cnt_dec;
            if (last) res <= normalize(q_nxt, r_nxt != '0);
        end
endmodule

// File: tb/tb_div_mant.sv
// tb_div_mant: scoreboard bench for div_mant against floor(A*2^24/B)
module tb_div_mant;
    import div_mant_pkg::*;

    typedef struct {
        logic [23:0] out;
        logic        exp_dec;
        logic        sticky;
        logic        dbz;
        int          due;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q_exp[$];
    exp_t last;
    bit   have_last = 0;

    div_mant_if bus();
    div_mant dut (.CLK(clk), .RST(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b);
        exp_t m;
        logic [47:0] n, qq, rr;
        m.due = 0;
        if (b == 0) begin
            m.out = 0; m.exp_dec = 0; m.sticky = 0; m.dbz = 1;
        end else begin
            n  = {a, 24'b0};
            qq = n / {24'b0, b};
            rr = n % {24'b0, b};
            m.out     = qq[24] ? qq[24:1] : qq[23:0];
            m.exp_dec = ~qq[24];
            m.sticky  = (rr != 0) | (qq[24] & qq[0]);
            m.dbz     = 0;
        end
        return m;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.done) begin
            if (q_exp.size() == 0) chk("spurious_done", 1, 0);
            else begin
                e = q_exp.pop_front();
                chk("latency", cyc, e.due);
                chk("out", bus.out, e.out);
                chk("exp_dec", bus.exp_dec, e.exp_dec);
                chk("sticky", bus.sticky, e.sticky);
                chk("dbz", bus.dbz, e.dbz);
                last = e;
                have_last = 1;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", bus.busy, 0);
    endtask

    task automatic do_op(input logic [23:0] a, input logic [23:0] b);
        exp_t e;
        wait_idle();
        if (have_last) begin
            chk("hold_out", bus.out, last.out);
            chk("hold_dbz", bus.dbz, last.dbz);
        end
        bus.A = a;
        bus.B = b;
        bus.start = 1;
        e = model(a, b);
        e.due = cyc + ((b == 0) ? 1 : 26);
        q_exp.push_back(e);
        @(posedge clk); #1;
        bus.start = 0;
        chk("busy_accept", bus.busy, 1);
        chk("out_clear", bus.out, 0);
    endtask

    initial begin
        int n;
        bus.start = 0; bus.A = 0; bus.B = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_flags", {bus.exp_dec, bus.sticky, bus.dbz}, 0);
        rst_n = 1;

        do_op(24'h800000, 24'h800000);
        do_op(24'hC00000, 24'h800000);
        do_op(24'h800000, 24'hC00000);
        do_op(24'hFFFFFF, 24'h800000);
        do_op(24'h800000, 24'hFFFFFF);

        do_op(24'h000000, 24'h000000);
        wait_idle();
        chk("dbz_busy_after", bus.busy, 0);
        do_op(24'h900000, 24'h000000);
        do_op(24'hA00000, 24'hB00000);

        // ignored start mid-run and input changes after accept
        do_op(24'hC00000, 24'h800000);
        repeat (4) @(posedge clk);
        #1;
        bus.A = 24'h123456; bus.B = 24'h000000;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;

        // reset mid-operation aborts with no done
        do_op(24'h800000, 24'hC00000);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_out", bus.out, 0);
        chk("abort_flags", {bus.exp_dec, bus.sticky, bus.dbz}, 0);
        q_exp.delete();
        have_last = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        do_op(24'hE00000, 24'h900000);

        for (int i = 0; i < 1500; i++)
            do_op({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)});

        wait_idle();
        n = 0;
        while (q_exp.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain", q_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
